// File: rtl/la_iogpio.sv
// GPIO controller for an array of bidirectional pads: register file driving pad controls,
// synchronized and glitch-filtered inputs, and sticky rising-edge interrupts.
module la_iogpio #(
  parameter int unsigned N    = 8,
  parameter int unsigned FILT = 3,
  parameter int unsigned FW   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reg_wen,
  input  logic         reg_ren,
  input  logic [2:0]   reg_addr,
  input  logic [N-1:0] reg_wdata,
  output logic [N-1:0] reg_rdata,
  output logic         reg_rvalid,
  output logic         irq,
  output logic [N-1:0] pad_a,
  output logic [N-1:0] pad_oe,
  output logic [N-1:0] pad_ie,
  output logic [N-1:0] pad_pe,
  output logic [N-1:0] pad_ps,
  input  logic [N-1:0] pad_z
);

  localparam logic [2:0] A_DOUT   = 3'd0;
  localparam logic [2:0] A_OE     = 3'd1;
  localparam logic [2:0] A_IE     = 3'd2;
  localparam logic [2:0] A_PE     = 3'd3;
  localparam logic [2:0] A_PS     = 3'd4;
  localparam logic [2:0] A_IRQEN  = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_DIN    = 3'd7;

  logic [N-1:0] irqen;
  logic [N-1:0] status;
  logic [N-1:0] status_next;
  logic [N-1:0] w1c;
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] din;
  logic [N-1:0] din_next;
  logic [N-1:0] rd_mux;

  // Configuration registers; pad controls are the register flops themselves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_a  <= '0;
      pad_oe <= '0;
      pad_ie <= '0;
      pad_pe <= '0;
      pad_ps <= '0;
      irqen  <= '0;
      status <= '0;
    end else begin
      if (reg_wen) begin
        case (reg_addr)
          A_DOUT:  pad_a  <= reg_wdata;
          A_OE:    pad_oe <= reg_wdata;
          A_IE:    pad_ie <= reg_wdata;
          A_PE:    pad_pe <= reg_wdata;
          A_PS:    pad_ps <= reg_wdata;
          A_IRQEN: irqen  <= reg_wdata;
          default: ;
        endcase
      end
      status <= status_next;
    end
  end

  // Sticky status: a rising edge in the same cycle as a W1C clear keeps the bit set.
  always_comb begin
    w1c = '0;
    if (reg_wen && (reg_addr == A_STATUS)) begin
      w1c = reg_wdata;
    end
    status_next = (status & ~w1c) | (din_next & ~din & irqen);
  end

  assign irq = |(status & irqen);

  // Two-flop synchronizer, gated by the input enable, then the filtered value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      din <= '0;
    end else begin
      s1  <= pad_z & pad_ie;
      s2  <= s1;
      din <= din_next;
    end
  end

  generate
    if (FILT == 0) begin : g_nofilt
      assign din_next = s2;
    end else begin : g_filt
      localparam logic [FW-1:0] CNT_LAST = FW'(FILT - 1);
      logic [N-1:0][FW-1:0] cnt;
      logic [N-1:0][FW-1:0] cnt_next;

      // din follows s2 only after FILT consecutive differing edges.
      always_comb begin
        din_next = din;
        cnt_next = cnt;
        for (int unsigned i = 0; i < N; i++) begin
          if (s2[i] == din[i]) begin
            cnt_next[i] = '0;
          end else if (cnt[i] == CNT_LAST) begin
            din_next[i] = s2[i];
            cnt_next[i] = '0;
          end else begin
            cnt_next[i] = cnt[i] + FW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_DOUT:   rd_mux = pad_a;
      A_OE:     rd_mux = pad_oe;
      A_IE:     rd_mux = pad_ie;
      A_PE:     rd_mux = pad_pe;
      A_PS:     rd_mux = pad_ps;
      A_IRQEN:  rd_mux = irqen;
      A_STATUS: rd_mux = status;
      A_DIN:    rd_mux = din;
      default:  rd_mux = '0;
    endcase
  end

  // Read data sampled from pre-edge register values, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_ren;
      if (reg_ren) begin
        reg_rdata <= rd_mux;
      end
    end
  end

endmodule
